fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Sequences instruction fetch: owns the PC, issues single-outstanding req/ack reads to instruction memory.
//   Presents fetched instruction + PC to decode with valid/stall (hazard) flow control.
//   Handles EX-stage redirects, including discarding an in-flight read; 1-entry skid buffer absorbs late stalls.
//   Sits between the hazard unit / EX branch resolution and the IF/ID pipeline register.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC loaded on reset
//   XLEN      32             address/instruction width
// PORTS
//   clk          in   1     clock, all state on rising edge
//   rst          in   1     asynchronous, active-high reset
//   hazard       in   1     decode stall; output not consumed this cycle
//   redirect     in   1     EX branch/jump taken; flush and refetch
//   redirect_pc  in   XLEN  target PC, valid with redirect
//   imem_req     out  1     read request to instruction memory
//   imem_addr    out  XLEN  read address, stable while imem_req high
//   imem_ack     in   1     read done; meaningful only while imem_req high
//   imem_rdata   in   XLEN  instruction word, valid with imem_ack
//   if_valid     out  1     if_instr/if_pc/if_pc4 valid
//   if_instr     out  XLEN  fetched instruction
//   if_pc        out  XLEN  PC of if_instr
//   if_pc4       out  XLEN  if_pc + 4
// BEHAVIOUR
//   Reset: state IDLE, pc=RESET_PC, skid empty; imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr/if_pc=0, if_pc4=4.
//   Consume: output transfers at an edge with if_valid=1 && hazard=0.
//   IMEM rule: once imem_req is high it stays high, address unchanged, until imem_ack; no withdrawal.
//   IDLE: req=0; go FETCH next cycle.
//   FETCH: req=1, addr=pc. Cycle without ack and without redirect: stay.
//     ack && !redirect: pc<=pc+4.
//       If output free (!if_valid || !hazard): load output (if_valid=1 next cycle), stay FETCH.
//       Else: load skid, go STALL.
//     ack-to-if_valid latency is 1 cycle; back-to-back acks give one instruction per cycle.
//   STALL: req=0; output held. When hazard=0: output<=skid, skid empties, go FETCH.
//   Redirect (priority over hazard, any state): pc<=redirect_pc, if_valid<=0, skid emptied.
//     FETCH with ack same cycle: rdata discarded, go FETCH at redirect_pc.
//     FETCH without ack: go DROP.
//     IDLE/STALL: go FETCH.
//   DROP: req=1 at the old address until ack; rdata discarded; then FETCH at the redirected pc.
//     A further redirect in DROP updates pc and stays in DROP.
//   PC and if_pc4 arithmetic are modulo 2^XLEN: 0xFFFF_FFFC + 4 = 0.
//   Async reset mid-operation: all outputs go to their reset values immediately; no in-flight state survives.
// CONFIGURATION
//   FETCH_CTRL_PERF_EN defined:
//     Adds out ports perf_fetch_cnt [31:0] (+1 per consumed instruction) and perf_stall_cnt [31:0] (+1 per cycle with if_valid && hazard).
//     Counters wrap and are cleared by rst.
//   Macro undefined: ports and counters are absent.
// STRUCTURE
//   fetch_pkg holds fetch_state_e {IDLE, FETCH, STALL, DROP}, the PC_INC=4 constant and the fetch_out_t struct {instr, pc}.
//   One sub-module: fetch_skid_buf, a 1-entry fetch_out_t buffer with load/unload/flush.
//   FSM, PC and output register stay in fetch_ctrl.
// TESTING
//   1 Reset release, imem_ack tied 1 -> imem_addr 0,4,8,...; if_valid from 2nd cycle after IDLE; if_pc=0, if_pc4=4, if_instr=mem[0].
//   2 hazard high 3 cycles during streaming -> skid used, STALL with req=0; after release order 0,4,8 intact, no loss or duplicate.
//   3 ack delay 3 cycles, redirect to 0x100 one cycle after req -> DROP with addr held; that rdata is never valid; next req addr 0x100.
//   4 redirect to 0x200 in the same cycle as ack -> if_valid=0 next cycle; next imem_addr 0x200; discarded word never appears.
//   5 rst asserted mid-DROP (no clock edge) -> imem_req=0, if_valid=0 immediately; restart at RESET_PC.
//   6 redirect_pc=0xFFFF_FFFC -> if_pc4=0; next imem_addr 0x0000_0000.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Struct fields are FETCH_XLEN wide; fetch_ctrl's XLEN parameter must match FETCH_XLEN.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [FETCH_XLEN-1:0] PC_INC = FETCH_XLEN'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_out_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction memory req/ack bus between the fetch controller and instruction memory.
// master: fetch side (drives req/addr); slave: memory side (drives ack/rdata).
interface fetch_ctrl_if
    import fetch_pkg::*;
#(
    parameter int XLEN = FETCH_XLEN
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry buffer holding a fetched word that arrived while decode was stalled.
// Flush wins over load, load wins over unload.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       unload,
    input  logic       flush,
    input  fetch_out_t din,
    output logic       valid,
    output fetch_out_t dout
);

    logic       valid_q;
    fetch_out_t data_q;

    // Capture a word on load, release it on unload, drop it on flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= din;
        end else if (unload) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues single-outstanding reads to
// instruction memory, and presents instruction/PC to decode with valid/hazard flow control.
// Optional build macro FETCH_CTRL_PERF_EN adds fetch and stall performance counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    fetch_ctrl_if.master      imem,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_instr,
    output logic [XLEN-1:0]   if_pc,
    output logic [XLEN-1:0]   if_pc4
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] drop_addr_q;
    logic            out_valid_q;
    fetch_out_t      out_q;
    fetch_out_t      fetch_word;
    fetch_out_t      skid_dout;
    logic            skid_valid;

    logic            ack;
    logic            consume;
    logic            out_free;
    logic            fetch_hit;
    logic            load_out;
    logic            load_skid;
    logic            unload_skid;

    assign ack        = imem.imem_ack;
    assign consume    = out_valid_q && !hazard;
    assign out_free   = !out_valid_q || !hazard;
    assign fetch_word = '{instr: imem.imem_rdata, pc: pc_q};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect overrides any stall decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    state_d = ack ? FETCH : DROP;
                end else if (ack && !out_free) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (redirect || !hazard) begin
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory request outputs and datapath strobes; DROP keeps the abandoned address on the bus
    always_comb begin
        imem.imem_req  = (state_q == FETCH) || (state_q == DROP);
        imem.imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
        fetch_hit      = (state_q == FETCH) && ack && !redirect;
        load_out       = fetch_hit && out_free;
        load_skid      = fetch_hit && !out_free;
        unload_skid    = (state_q == STALL) && !hazard && !redirect && skid_valid;
    end

    // PC advances on each accepted word and jumps on redirect; remember the in-flight address when a redirect orphans it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            if (redirect) begin
                pc_q <= redirect_pc;
            end else if (fetch_hit) begin
                pc_q <= pc_q + PC_INC;
            end
            if ((state_q == FETCH) && redirect && !ack) begin
                drop_addr_q <= pc_q;
            end
        end
    end

    // Decode-facing output register: flush on redirect, refill from memory or skid, empty when consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (redirect) begin
            out_valid_q <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_q       <= fetch_word;
        end else if (unload_skid) begin
            out_valid_q <= 1'b1;
            out_q       <= skid_dout;
        end else if (consume) begin
            out_valid_q <= 1'b0;
        end
    end

    fetch_skid_buf u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (load_skid),
        .unload (unload_skid),
        .flush  (redirect),
        .din    (fetch_word),
        .valid  (skid_valid),
        .dout   (skid_dout)
    );

    assign if_valid = out_valid_q;
    assign if_instr = out_q.instr;
    assign if_pc    = out_q.pc;
    assign if_pc4   = out_q.pc + PC_INC;

`ifdef FETCH_CTRL_PERF_EN
    // Count consumed instructions and cycles where a valid output is held by hazard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (consume) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (out_valid_q && hazard) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: streaming, stall/skid, redirects
// (with and without same-cycle ack), async reset mid-DROP and PC wrap-around.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        hazard;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int errors;
    int checks;
    int ack_delay;
    int wait_cnt;

    fetch_ctrl_if #(.XLEN(32)) imem ();

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .hazard      (hazard),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Memory contents: a distinct word per address
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ack after ack_delay cycles of an outstanding request
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
        end else if (imem.imem_req && !imem.imem_ack) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    assign imem.imem_ack   = imem.imem_req && (wait_cnt >= ack_delay);
    assign imem.imem_rdata = memWord(imem.imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic h, input logic r, input logic [31:0] rpc);
        hazard      = h;
        redirect    = r;
        redirect_pc = rpc;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed test sequence
    initial begin
        errors    = 0;
        checks    = 0;
        ack_delay = 0;
        rst       = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Reset values
        #3;
        checkOutput("rst_req",   {31'b0, imem.imem_req}, 32'd0);
        checkOutput("rst_addr",  imem.imem_addr, 32'h0);
        checkOutput("rst_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("rst_instr", if_instr, 32'h0);
        checkOutput("rst_pc",    if_pc, 32'h0);
        checkOutput("rst_pc4",   if_pc4, 32'h4);

        // Streaming with ack tied high
        tick();
        rst = 1'b0;
        tick();
        checkOutput("t1_req",    {31'b0, imem.imem_req}, 32'd1);
        checkOutput("t1_addr0",  imem.imem_addr, 32'h0);
        checkOutput("t1_valid0", {31'b0, if_valid}, 32'd0);
        tick();
        checkOutput("t1_valid1", {31'b0, if_valid}, 32'd1);
        checkOutput("t1_pc0",    if_pc, 32'h0);
        checkOutput("t1_pc4_0",  if_pc4, 32'h4);
        checkOutput("t1_instr0", if_instr, memWord(32'h0));
        checkOutput("t1_addr4",  imem.imem_addr, 32'h4);
        tick();
        checkOutput("t1_pc4",    if_pc, 32'h4);
        checkOutput("t1_addr8",  imem.imem_addr, 32'h8);
        tick();
        checkOutput("t1_pc8",    if_pc, 32'h8);
        checkOutput("t1_addrC",  imem.imem_addr, 32'hC);

        // Hazard for three cycles: word 0xC goes to the skid buffer
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t2_stall_req",   {31'b0, imem.imem_req}, 32'd0);
            checkOutput("t2_stall_valid", {31'b0, if_valid}, 32'd1);
            checkOutput("t2_stall_pc",    if_pc, 32'h8);
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t2_skid_pc",    if_pc, 32'hC);
        checkOutput("t2_skid_instr", if_instr, memWord(32'hC));
        checkOutput("t2_resume_req", {31'b0, imem.imem_req}, 32'd1);
        checkOutput("t2_resume_addr", imem.imem_addr, 32'h10);
        tick();
        checkOutput("t2_next_pc",    if_pc, 32'h10);
        checkOutput("t2_next_valid", {31'b0, if_valid}, 32'd1);

        // Redirect while a slow read is outstanding -> DROP
        rst       = 1'b1;
        ack_delay = 3;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("t3_req",  {31'b0, imem.imem_req}, 32'd1);
        checkOutput("t3_addr", imem.imem_addr, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h100);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t3_drop_req",   {31'b0, imem.imem_req}, 32'd1);
        checkOutput("t3_drop_addr",  imem.imem_addr, 32'h0);
        checkOutput("t3_drop_valid", {31'b0, if_valid}, 32'd0);
        tick();
        checkOutput("t3_hold_addr1", imem.imem_addr, 32'h0);
        tick();
        checkOutput("t3_hold_addr2", imem.imem_addr, 32'h0);
        tick();
        checkOutput("t3_new_addr",  imem.imem_addr, 32'h100);
        checkOutput("t3_new_valid", {31'b0, if_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t3_wait_valid", {31'b0, if_valid}, 32'd0);
        end
        tick();
        checkOutput("t3_valid", {31'b0, if_valid}, 32'd1);
        checkOutput("t3_pc",    if_pc, 32'h100);
        checkOutput("t3_instr", if_instr, memWord(32'h100));
        checkOutput("t3_addr_next", imem.imem_addr, 32'h104);

        // Redirect in the same cycle as ack -> word discarded
        ack_delay = 0;
        applyStimulus(1'b0, 1'b1, 32'h200);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t4_valid0", {31'b0, if_valid}, 32'd0);
        checkOutput("t4_addr",   imem.imem_addr, 32'h200);
        tick();
        checkOutput("t4_valid1", {31'b0, if_valid}, 32'd1);
        checkOutput("t4_pc",     if_pc, 32'h200);
        checkOutput("t4_instr",  if_instr, memWord(32'h200));

        // Redirect to the top of the address space -> PC wraps to 0
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t6_addr_top", imem.imem_addr, 32'hFFFF_FFFC);
        tick();
        checkOutput("t6_pc_top",   if_pc, 32'hFFFF_FFFC);
        checkOutput("t6_pc4_wrap", if_pc4, 32'h0);
        checkOutput("t6_addr_wrap", imem.imem_addr, 32'h0);
        tick();
        checkOutput("t6_pc_wrap",  if_pc, 32'h0);
        checkOutput("t6_pc4_next", if_pc4, 32'h4);

        // Async reset while in DROP
        ack_delay = 3;
        applyStimulus(1'b0, 1'b1, 32'h300);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t5_drop_addr", imem.imem_addr, 32'h4);
        checkOutput("t5_drop_req",  {31'b0, imem.imem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_req",   {31'b0, imem.imem_req}, 32'd0);
        checkOutput("t5_rst_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("t5_rst_addr",  imem.imem_addr, 32'h0);
        checkOutput("t5_rst_pc4",   if_pc4, 32'h4);
        ack_delay = 0;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("t5_restart_addr", imem.imem_addr, 32'h0);
        tick();
        checkOutput("t5_restart_valid", {31'b0, if_valid}, 32'd1);
        checkOutput("t5_restart_pc",    if_pc, 32'h0);
        checkOutput("t5_restart_instr", if_instr, memWord(32'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
